// File: rtl/matmul_apb_seq.sv
// matmul_apb_seq: APB-slave matrix-multiply engine.
// Computes C[NxM] = A[NxK] * B[KxM] (+ optional bias taken from the target bank)
// using one signed MAC per cycle. Results land in one of SP_NTARGETS scratchpad banks.
//
// APB handshake: a transfer is a setup phase (psel & ~penable) followed by one
// access phase (psel & penable). The slave never inserts wait states, so
// pready_o = psel & penable. Read data is captured at the setup edge and held;
// pslverr_o is valid only while pready_o is high. Writes commit at the access edge.
module matmul_apb_seq #(
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [BUS_WIDTH/8-1:0]  pstrb_i,
    input  logic [BUS_WIDTH-1:0]    pwdata_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic [BUS_WIDTH-1:0]    prdata_o,
    output logic                    busy_o
);

    localparam int SW    = 2 * DATA_WIDTH;
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int WSH   = $clog2(BYTES);

    localparam logic [2:0]  MD      = 3'(MAX_DIM);
    localparam logic [2:0]  NT      = 3'(SP_NTARGETS);
    // Writable CTRL bits: bias, wtarget, rtarget, N-1, K-1, M-1 (start is a pulse).
    localparam logic [15:0] CTRL_RW = 16'h3F3E;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_MAC   = 2'd2;
    localparam logic [1:0] S_STORE = 2'd3;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] a_mem  [MAX_DIM][MAX_DIM];
    logic [DATA_WIDTH-1:0] b_mem  [MAX_DIM][MAX_DIM];
    logic [SW-1:0]         sp_mem [SP_NTARGETS][MAX_DIM][MAX_DIM];
    logic [15:0]           ctrl_q;
    logic [BUS_WIDTH-1:0]  prdata_q;

    // Engine state
    logic [1:0]    state_q;
    logic [1:0]    i_q, j_q, k_q;
    logic [1:0]    n_last_q, k_last_q, m_last_q;
    logic          bias_q;
    logic [1:0]    wt_q;
    logic [SW-1:0] acc_q;
    logic [15:0]   ovf_q;
    logic          done_q;

    logic busy;
    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0] row, col, tgt;
    logic is_ctrl, is_status, is_a, is_b, is_sp, rc_ok;

    assign widx      = paddr_i >> WSH;
    assign row       = widx[3:2];
    assign col       = widx[1:0];
    assign tgt       = widx[5:4];
    assign is_ctrl   = (widx == '0);
    assign is_status = (widx == ADDR_WIDTH'(1));
    assign is_a      = (widx >= ADDR_WIDTH'(16)) && (widx < ADDR_WIDTH'(32));
    assign is_b      = (widx >= ADDR_WIDTH'(32)) && (widx < ADDR_WIDTH'(48));
    assign is_sp     = (widx >= ADDR_WIDTH'(64)) && (widx < ADDR_WIDTH'(128));
    assign rc_ok     = ({1'b0, row} < MD) && ({1'b0, col} < MD);

    // Expand byte strobes into a bit mask
    logic [BUS_WIDTH-1:0] bus_mask;
    always_comb begin
        bus_mask = '0;
        for (int b = 0; b < BYTES; b++) begin
            bus_mask[b*8 +: 8] = {8{pstrb_i[b]}};
        end
    end

    // Byte-merged candidate values for each writable target
    logic [15:0]           ctrl_wr;
    logic [DATA_WIDTH-1:0] a_wr, b_wr;
    assign ctrl_wr = (ctrl_q & ~bus_mask[15:0]) | (pwdata_i[15:0] & bus_mask[15:0]);
    assign a_wr    = (a_mem[row][col] & ~bus_mask[DATA_WIDTH-1:0])
                   | (pwdata_i[DATA_WIDTH-1:0] & bus_mask[DATA_WIDTH-1:0]);
    assign b_wr    = (b_mem[row][col] & ~bus_mask[DATA_WIDTH-1:0])
                   | (pwdata_i[DATA_WIDTH-1:0] & bus_mask[DATA_WIDTH-1:0]);

    // A start is only legal if the bank exists and every dimension fits
    logic start_bad;
    assign start_bad = ({1'b0, ctrl_wr[3:2]}   >= NT)
                    || ({1'b0, ctrl_wr[9:8]}   >  (MD - 3'd1))
                    || ({1'b0, ctrl_wr[11:10]} >  (MD - 3'd1))
                    || ({1'b0, ctrl_wr[13:12]} >  (MD - 3'd1));

    // Classify the current transfer as erroneous (no state change, pslverr)
    logic err;
    always_comb begin
        err = 1'b0;
        if (is_ctrl) begin
            if (pwrite_i && (busy || (ctrl_wr[0] && start_bad))) err = 1'b1;
        end else if (is_status) begin
            err = pwrite_i;
        end else if (is_a || is_b) begin
            err = !rc_ok || (pwrite_i && busy);
        end else if (is_sp) begin
            err = !rc_ok || pwrite_i || ({1'b0, tgt} >= NT);
        end else begin
            err = 1'b1;
        end
    end

    logic setup_ph, access_ph, wr_ok, start_ok;
    assign setup_ph  = psel_i & ~penable_i;
    assign access_ph = psel_i & penable_i;
    assign wr_ok     = access_ph & pwrite_i & ~err;
    assign start_ok  = wr_ok & is_ctrl & ctrl_wr[0];

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [SW-1:0] sp_rd;
    always_comb begin
        sp_rd = '0;
        for (int t = 0; t < SP_NTARGETS; t++) begin
            if (tgt == 2'(t)) sp_rd = sp_mem[t][row][col];
        end
    end

    logic [31:0] status_word;
    assign status_word = {ovf_q, 14'b0, done_q, busy};

    logic [BUS_WIDTH-1:0] rdata;
    always_comb begin
        rdata = '0;
        if (is_ctrl)        rdata = BUS_WIDTH'(ctrl_q);
        else if (is_status) rdata = BUS_WIDTH'(status_word);
        else if (is_a)      rdata = BUS_WIDTH'(a_mem[row][col]);
        else if (is_b)      rdata = BUS_WIDTH'(b_mem[row][col]);
        else if (is_sp)     rdata = BUS_WIDTH'(sp_rd);
    end

    // ------------------------------------------------------------------
    // Register file: CTRL, A, B and captured read data
    // ------------------------------------------------------------------
    // Capture read data in setup phase; commit writes in access phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            prdata_q <= '0;
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int c = 0; c < MAX_DIM; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else begin
            if (setup_ph) prdata_q <= (!pwrite_i && !err) ? rdata : '0;
            if (wr_ok) begin
                if (is_ctrl) ctrl_q <= ctrl_wr & CTRL_RW;
                if (is_a)    a_mem[row][col] <= a_wr;
                if (is_b)    b_mem[row][col] <= b_wr;
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] a_cur, b_cur;
    logic [SW-1:0]         prod, sum, sp_bias;
    logic                  add_ovf;

    assign a_cur = a_mem[i_q][k_q];
    assign b_cur = b_mem[k_q][j_q];
    // Sign-extend both operands so the low SW bits of the product are exact.
    assign prod  = {{DATA_WIDTH{a_cur[DATA_WIDTH-1]}}, a_cur}
                 * {{DATA_WIDTH{b_cur[DATA_WIDTH-1]}}, b_cur};
    assign sum     = acc_q + prod;
    assign add_ovf = (acc_q[SW-1] == prod[SW-1]) && (sum[SW-1] != acc_q[SW-1]);

    always_comb begin
        sp_bias = '0;
        for (int t = 0; t < SP_NTARGETS; t++) begin
            if (wt_q == 2'(t)) sp_bias = sp_mem[t][i_q][j_q];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: IDLE -> LOAD -> MAC (K cycles) -> STORE -> LOAD | IDLE
    // ------------------------------------------------------------------
    // Walk the result elements row-major; one element costs K+2 cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            n_last_q <= '0;
            k_last_q <= '0;
            m_last_q <= '0;
            bias_q   <= 1'b0;
            wt_q     <= '0;
            acc_q    <= '0;
            ovf_q    <= '0;
            done_q   <= 1'b0;
            for (int t = 0; t < SP_NTARGETS; t++) begin
                for (int r = 0; r < MAX_DIM; r++) begin
                    for (int c = 0; c < MAX_DIM; c++) begin
                        sp_mem[t][r][c] <= '0;
                    end
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        n_last_q <= ctrl_wr[9:8];
                        k_last_q <= ctrl_wr[11:10];
                        m_last_q <= ctrl_wr[13:12];
                        bias_q   <= ctrl_wr[1];
                        wt_q     <= ctrl_wr[3:2];
                        ovf_q    <= '0;
                        done_q   <= 1'b0;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_q   <= bias_q ? sp_bias : '0;
                    k_q     <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    acc_q <= sum;
                    if (add_ovf) ovf_q[{i_q, j_q}] <= 1'b1;
                    if (k_q == k_last_q) begin
                        state_q <= S_STORE;
                    end else begin
                        k_q <= k_q + 2'd1;
                    end
                end
                S_STORE: begin
                    for (int t = 0; t < SP_NTARGETS; t++) begin
                        if (wt_q == 2'(t)) sp_mem[t][i_q][j_q] <= acc_q;
                    end
                    if (j_q == m_last_q) begin
                        j_q <= '0;
                        if (i_q == n_last_q) begin
                            i_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            i_q     <= i_q + 2'd1;
                            state_q <= S_LOAD;
                        end
                    end else begin
                        j_q     <= j_q + 2'd1;
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus bits that no register consumes
    logic unused_bits;
    assign unused_bits = ^{pwdata_i, bus_mask, widx};

    assign pready_o  = access_ph;
    assign pslverr_o = access_ph & err;
    assign prdata_o  = prdata_q;
    assign busy_o    = busy;

endmodule

// File: tb/tb_matmul_apb_seq.sv
// Testbench for matmul_apb_seq: directed scenarios plus randomized runs,
// checked against a plain-arithmetic matrix model held in the bench.
module tb_matmul_apb_seq;

  localparam logic signed [65:0] MAXV = 66'sd9223372036854775807;
  localparam logic signed [65:0] MINV = -66'sd9223372036854775808;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  pstrb;
  logic [63:0] pwdata;
  logic [31:0] paddr;
  logic        pready, pslverr, busy;
  logic [63:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  // Reference model state
  logic signed [31:0] m_a [4][4];
  logic signed [31:0] m_b [4][4];
  logic [63:0]        m_sp[2][4][4];
  logic [15:0]        m_ovf;
  logic               m_done;
  logic [15:0]        m_ctrl;

  matmul_apb_seq dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .pstrb_i   (pstrb),
    .pwdata_i  (pwdata),
    .paddr_i   (paddr),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .prdata_o  (prdata),
    .busy_o    (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] waddr(input int w);
    return 32'(w * 8);
  endfunction

  function automatic logic [15:0] ctrl_word(input bit start, input bit bias, input int wt,
                                             input int n, input int k, input int m);
    return 16'(start) | (16'(bias) << 1) | (16'(wt) << 2)
         | (16'(n - 1) << 8) | (16'(k - 1) << 10) | (16'(m - 1) << 12);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apb_write(input int w, input logic [63:0] data, input logic [7:0] strb,
                           output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = waddr(w); pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("wr_pready", 64'(pready), 64'd1);
    check("wr_prdata", prdata, 64'd0);
    err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input int w, output logic [63:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = waddr(w); pstrb = 8'h00;
    @(negedge clk);
    penable = 1'b1;
    #1;
    check("rd_pready", 64'(pready), 64'd1);
    data = prdata;
    err  = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic write_a(input int r, input int c, input logic [31:0] v);
    logic err;
    apb_write(16 + r * 4 + c, {32'hCAFE_0000 | 32'(r * 4 + c), v}, 8'hFF, err);
    check("wr_a_err", 64'(err), 64'd0);
    m_a[r][c] = v;
  endtask

  task automatic write_b(input int r, input int c, input logic [31:0] v);
    logic err;
    apb_write(32 + r * 4 + c, {32'h0, v}, 8'hFF, err);
    check("wr_b_err", 64'(err), 64'd0);
    m_b[r][c] = v;
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m_a[r][c] = '0;
        m_b[r][c] = '0;
        for (int t = 0; t < 2; t++) m_sp[t][r][c] = '0;
      end
    m_ovf = '0; m_done = 1'b0; m_ctrl = '0;
  endtask

  task automatic model_run(input int n, input int k, input int m, input bit bias, input int wt);
    logic signed [63:0] acc, prod;
    logic signed [65:0] wide;
    m_ovf = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < m; j++) begin
        acc = bias ? m_sp[wt][i][j] : 64'sd0;
        for (int kk = 0; kk < k; kk++) begin
          prod = 64'(m_a[i][kk]) * 64'(m_b[kk][j]);
          wide = 66'(acc) + 66'(prod);
          if (wide > MAXV || wide < MINV) m_ovf[i * 4 + j] = 1'b1;
          acc = wide[63:0];
        end
        m_sp[wt][i][j] = acc;
      end
    m_done = 1'b1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check_sp_all(input string tag);
    logic [63:0] d, e;
    logic err;
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) exp_q.push_back(m_sp[t][r][c]);
    for (int t = 0; t < 2; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          apb_read(64 + t * 16 + r * 4 + c, d, err);
          e = exp_q.pop_front();
          check({tag, "_sp_err"}, 64'(err), 64'd0);
          check($sformatf("%s_sp%0d_%0d_%0d", tag, t, r, c), d, e);
        end
  endtask

  task automatic check_status(input string tag);
    logic [63:0] d;
    logic err;
    apb_read(1, d, err);
    check({tag, "_status_err"}, 64'(err), 64'd0);
    check({tag, "_status"}, d, {32'h0, m_ovf, 14'h0, m_done, 1'b0});
  endtask

  task automatic start_run(input int n, input int k, input int m, input bit bias,
                           input int wt, input string tag);
    logic err;
    logic [15:0] cv;
    cv = ctrl_word(1'b1, bias, wt, n, k, m);
    apb_write(0, 64'(cv), 8'hFF, err);
    check({tag, "_start_err"}, 64'(err), 64'd0);
    m_ctrl = cv & 16'h3F3E;
    model_run(n, k, m, bias, wt);
  endtask

  task automatic do_run(input int n, input int k, input int m, input bit bias,
                        input int wt, input string tag);
    int cnt;
    start_run(n, k, m, bias, wt, tag);
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(n * m * (k + 2)));
    check_status(tag);
    check_sp_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] d;
    logic err;
    int cnt, n, k, m, wt;
    bit bias;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pstrb = '0; pwdata = '0; paddr = '0;
    model_reset();

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_pslverr", 64'(pslverr), 64'd0);
    check("rst_prdata", prdata, 64'd0);
    rst = 1'b0;
    apb_read(0, d, err);  check("rst_ctrl", d, 64'd0);
    apb_read(1, d, err);  check("rst_status", d, 64'd0);
    apb_read(16, d, err); check("rst_a00", d, 64'd0);
    apb_read(47, d, err); check("rst_b33", d, 64'd0);
    apb_read(64, d, err); check("rst_sp000", d, 64'd0);
    apb_read(95, d, err); check("rst_sp133", d, 64'd0);

    // byte-strobed A write: only the low byte changes, upper lanes are ignored
    write_a(0, 0, 32'h1122_3344);
    apb_write(16, 64'hAABB_CCDD_0000_00EE, 8'h01, err);
    check("strb_err", 64'(err), 64'd0);
    apb_write(16, 64'hFFFF_FFFF_0000_0000, 8'hF0, err);
    apb_read(16, d, err);
    check("strb_a00", d, 64'h0000_0000_1122_33EE);
    m_a[0][0] = 32'h1122_33EE;

    // 2: 2x2 identity multiply into bank 0
    write_a(0, 0, 1); write_a(0, 1, 2); write_a(1, 0, 3); write_a(1, 1, 4);
    write_b(0, 0, 1); write_b(0, 1, 0); write_b(1, 0, 0); write_b(1, 1, 1);
    do_run(2, 2, 2, 1'b0, 0, "t2");
    apb_read(64 + 5, d, err);
    check("t2_sp011_const", d, 64'd4);

    // 3: same with bias -> doubled
    do_run(2, 2, 2, 1'b1, 0, "t3");
    apb_read(64 + 4, d, err);
    check("t3_sp010_const", d, 64'd6);

    // 3b: 1x1x1 signed product into bank 1 (upper pwdata bits must be dropped)
    apb_write(16, 64'hDEAD_BEEF_FFFF_FFFD, 8'hFF, err);
    m_a[0][0] = -32'sd3;
    write_b(0, 0, 5);
    do_run(1, 1, 1, 1'b0, 1, "t3b");
    apb_read(64 + 16, d, err);
    check("t3b_sp100_const", d, 64'hFFFF_FFFF_FFFF_FFF1);

    // 4: overflow on the K=4 chain of (-2^31)^2
    for (int i = 0; i < 4; i++) begin
      write_a(0, i, 32'h8000_0000);
      write_b(i, 0, 32'h8000_0000);
    end
    do_run(1, 4, 1, 1'b0, 0, "t4");
    apb_read(1, d, err);
    check("t4_status_const", d, 64'h0000_0000_0001_0002);
    apb_read(64, d, err);
    check("t4_sp000_const", d, 64'd0);

    // 5: error responses
    start_run(2, 2, 2, 1'b0, 1, "t5");
    apb_write(0, 64'(ctrl_word(1'b0, 1'b1, 0, 1, 1, 1)), 8'hFF, err);
    check("t5_ctrl_busy_err", 64'(err), 64'd1);
    check("t5_busy_kept", 64'(busy), 64'd1);
    apb_write(16, 64'h1234, 8'hFF, err);
    check("t5_a_busy_err", 64'(err), 64'd1);
    apb_read(17, d, err);
    check("t5_a_rd_busy_err", 64'(err), 64'd0);
    check("t5_a_rd_busy", d, {32'h0, m_a[0][1]});
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_busy_end", 64'(busy), 64'd0);
    check_status("t5");
    check_sp_all("t5");
    apb_write(1, 64'hFFFF, 8'hFF, err);
    check("t5_status_wr_err", 64'(err), 64'd1);
    apb_read(64 + 32, d, err);
    check("t5_sp_t2_err", 64'(err), 64'd1);
    check("t5_sp_t2_data", d, 64'd0);
    apb_write(64, 64'h5, 8'hFF, err);
    check("t5_sp_wr_err", 64'(err), 64'd1);
    apb_read(2, d, err);
    check("t5_unmapped_err", 64'(err), 64'd1);
    apb_write(0, 64'(ctrl_word(1'b1, 1'b0, 3, 2, 2, 2)), 8'hFF, err);
    check("t5_wt3_err", 64'(err), 64'd1);
    check("t5_wt3_busy", 64'(busy), 64'd0);
    apb_read(0, d, err);
    check("t5_ctrl_unchanged", d, 64'(m_ctrl));
    check_status("t5_after");

    // random runs against the model
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          write_a(r, c, $urandom);
          write_b(r, c, $urandom);
        end
      n = $urandom_range(1, 4); k = $urandom_range(1, 4); m = $urandom_range(1, 4);
      bias = 1'($urandom_range(0, 1));
      wt = $urandom_range(0, 1);
      do_run(n, k, m, bias, wt, $sformatf("rnd%0d", it));
    end

    // 6: reset in the middle of a 2x2x2 run
    start_run(2, 2, 2, 1'b0, 0, "t6");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy_after_rst", 64'(busy), 64'd0);
    check("t6_prdata_after_rst", prdata, 64'd0);
    rst = 1'b0;
    model_reset();
    check_status("t6_rst");
    apb_read(0, d, err);  check("t6_ctrl", d, 64'd0);
    apb_read(21, d, err); check("t6_a11", d, 64'd0);
    check_sp_all("t6_rst");
    write_a(0, 0, 7); write_a(0, 1, -32'sd2); write_a(1, 0, 1); write_a(1, 1, 9);
    write_b(0, 0, 3); write_b(0, 1, 4);       write_b(1, 0, 5); write_b(1, 1, -32'sd6);
    do_run(2, 2, 2, 1'b0, 1, "t6_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
